fft_filter_arbiter: RTL
=======================

Name: fft_filter_arbiter

Overview:
- Frame-granular round-robin arbiter that shares one frequency-domain filter multiplier (64-bit float32 complex AXI-Stream, 128x128 frames) between two FFT channel streams.
- Locks the multiplier to one channel from frame start to the tlast beat, then tags the frame.
- Routes the multiplier's output frame back to the originating channel's output port using an in-order tag FIFO.
- Sits between two FFT cores and the multiplier, upstream of the two IFFT paths.

Parameters:
- FRAME_BEATS, 16384, expected beats per frame (128x128); used only for the length check.
- TAG_DEPTH, 4, frames that may be in flight in the multiplier/output path; power of two, >=2.

Ports:
- aclk  in  1  clock
- aresetn  in  1  reset
- s0_axis_tvalid/tready/tdata/tlast  in/out/in/in  1/1/64/1  channel 0 FFT input ([63:32] real, [31:0] imag)
- s1_axis_tvalid/tready/tdata/tlast  in/out/in/in  1/1/64/1  channel 1 FFT input
- mul_m_axis_tvalid/tready/tdata/tlast  out/in/out/out  1/1/64/1  to multiplier input
- mul_s_axis_tvalid/tready/tdata/tlast  in/out/in/in  1/1/64/1  from multiplier output
- m0_axis_tvalid/tready/tdata/tlast  out/in/out/out  1/1/64/1  channel 0 filtered output
- m1_axis_tvalid/tready/tdata/tlast  out/in/out/out  1/1/64/1  channel 1 filtered output
- grant_id  out  1  channel currently locked; meaningful when busy=1
- busy  out  1  high in LOCK state
- frame_err  out  1  one-cycle pulse on a tlast beat whose frame length != FRAME_BEATS

Behaviour:
- Clock and reset: one clock, aclk. Reset aresetn is asynchronous, active-low. Reset clears the FSM to IDLE, last_grant=1 (so channel 0 wins first), beat_cnt=0, and empties the tag FIFO. All outputs reset to 0.
- Reset mid-frame: partial frames are discarded. Downstream must also be reset. No recovery is attempted.
- States: IDLE, LOCK.
- IDLE:
  - Candidates are channels with sN_axis_tvalid=1. Grant requires the tag FIFO not full.
  - Both valid: grant !last_grant. One valid: grant that channel.
  - On grant: register grant_id, set last_grant=grant_id, push grant_id into the tag FIFO, go to LOCK.
  - No beat is transferred in IDLE, so every frame start costs one bubble cycle.
- LOCK:
  - mul_m_axis_tvalid/tdata mirror the granted input.
  - Granted sN_axis_tready = mul_m_axis_tready. The other input's tready = 0.
  - mul_m_axis_tlast = granted tlast AND granted tvalid. It is never high without tvalid, because the multiplier resets its position counters on tlast alone.
  - beat_cnt increments on each mul_m handshake.
  - On the handshake with tlast=1: pulse frame_err next cycle if beat_cnt+1 != FRAME_BEATS; clear beat_cnt; go to IDLE.
  - beat_cnt saturates at FRAME_BEATS (a frame without tlast never wraps the count); such a frame is flagged at its eventual tlast.
- Outside LOCK: mul_m_axis_tvalid=0, tlast=0, and both s*_tready=0.
- Output routing is purely combinational, zero added latency:
  - FIFO non-empty: head h selects port. mh_axis_tvalid/tdata/tlast = mul_s_axis_*. mul_s_axis_tready = mh_axis_tready. The other m port's tvalid=0.
  - On the mul_s handshake with tlast=1: pop the FIFO.
  - FIFO empty: mul_s_axis_tready=0 and both m*_tvalid=0.
- Tag FIFO rules:
  - Push and pop in the same cycle are allowed; occupancy stays the same.
  - Full blocks new grants only. Output draining continues, and a pop in cycle N permits a grant in cycle N+1.
- Fairness: with both channels continuously valid, frames alternate 0,1,0,1.
- A channel asserting tvalid while the other is locked waits. Its tdata must be held per AXI-Stream.

Decomposition:
- Shared package fft_filt_pkg:
  - constants DATA_W=64, IMG_DIM=128, FRAME_BEATS_DEF=16384
  - FSM state enum {IDLE, LOCK}
- Sub-module tag_fifo:
  - 1-bit wide, TAG_DEPTH deep, sync FIFO with full/empty
  - same aclk and asynchronous active-low aresetn

Test Plan:
- Ch0 only, one 16384-beat frame, tlast on beat 16384, sinks always ready -> all beats appear on m0 in order; m1_tvalid never high; frame_err never pulses; busy low after tlast.
- Both channels valid from reset, 3 frames each, FRAME_BEATS=16 -> mul_m frame order 0,1,0,1,0,1; exactly one idle cycle between frames; m0 and m1 each receive 3 frames with matching data.
- Ch0 frame in flight, m0_tready held low 50 cycles, TAG_DEPTH=2, ch1 queued -> at most 2 grants issued, third grant only the cycle after the first output tlast pop; no data lost or misrouted.
- Ch1 frame with tlast on beat 10 (FRAME_BEATS=16) -> frame_err single pulse the cycle after that beat; arbiter returns to IDLE; next frame from ch0 is granted.
- Glitch tlast=1 with tvalid=0 on granted input -> mul_m_axis_tlast stays 0; beat_cnt unchanged.
- aresetn asserted asynchronously mid-frame between clock edges -> all valids/readys, busy, and grant_id go to 0 immediately; after release, first grant goes to ch0.

Source files
------------

// File: rtl/fft_filt_pkg.sv
// Shared constants and state type for the FFT filter arbiter slice.
package fft_filt_pkg;

  localparam int DATA_W          = 64;
  localparam int IMG_DIM         = 128;
  localparam int FRAME_BEATS_DEF = IMG_DIM * IMG_DIM;

  typedef enum logic {
    IDLE = 1'b0,
    LOCK = 1'b1
  } arb_state_t;

endpackage

// File: rtl/fft_filter_arbiter_tag_fifo.sv
// In-order FIFO of 1-bit channel tags, one entry per frame in flight
// between the arbiter grant and the multiplier output tlast.
module tag_fifo #(
  parameter int DEPTH = 4
) (
  input  logic aclk,
  input  logic aresetn,
  input  logic push,
  input  logic push_tag,
  input  logic pop,
  output logic head,
  output logic full,
  output logic empty
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [DEPTH-1:0] mem;
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W:0]   count;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == (PTR_W+1)'(DEPTH));
  assign empty   = (count == '0);
  assign head    = mem[rd_ptr];
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;

  // Storage, pointers (wrap naturally, DEPTH is a power of two) and occupancy.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      mem    <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= push_tag;
        wr_ptr      <= wr_ptr + PTR_W'(1);
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      case ({do_push, do_pop})
        2'b10:   count <= count + (PTR_W+1)'(1);
        2'b01:   count <= count - (PTR_W+1)'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/fft_filter_arbiter.sv
// Frame-granular round-robin arbiter sharing one filter multiplier between
// two FFT channel streams, with tag-FIFO routing of the multiplier output.
//
//   state | meaning
//   IDLE  | no channel locked; pick next channel if the tag FIFO has room
//   LOCK  | granted channel streams into the multiplier until its tlast beat
import fft_filt_pkg::*;

module fft_filter_arbiter #(
  parameter int FRAME_BEATS = FRAME_BEATS_DEF,
  parameter int TAG_DEPTH   = 4
) (
  input  logic              aclk,
  input  logic              aresetn,
  input  logic              s0_axis_tvalid,
  output logic              s0_axis_tready,
  input  logic [DATA_W-1:0] s0_axis_tdata,
  input  logic              s0_axis_tlast,
  input  logic              s1_axis_tvalid,
  output logic              s1_axis_tready,
  input  logic [DATA_W-1:0] s1_axis_tdata,
  input  logic              s1_axis_tlast,
  output logic              mul_m_axis_tvalid,
  input  logic              mul_m_axis_tready,
  output logic [DATA_W-1:0] mul_m_axis_tdata,
  output logic              mul_m_axis_tlast,
  input  logic              mul_s_axis_tvalid,
  output logic              mul_s_axis_tready,
  input  logic [DATA_W-1:0] mul_s_axis_tdata,
  input  logic              mul_s_axis_tlast,
  output logic              m0_axis_tvalid,
  input  logic              m0_axis_tready,
  output logic [DATA_W-1:0] m0_axis_tdata,
  output logic              m0_axis_tlast,
  output logic              m1_axis_tvalid,
  input  logic              m1_axis_tready,
  output logic [DATA_W-1:0] m1_axis_tdata,
  output logic              m1_axis_tlast,
  output logic              grant_id,
  output logic              busy,
  output logic              frame_err
);

  // One spare code above FRAME_BEATS so the saturated count still mismatches.
  localparam int             CNT_W   = $clog2(FRAME_BEATS + 2);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(FRAME_BEATS);

  arb_state_t        state;
  arb_state_t        state_nxt;
  logic              last_grant;
  logic              grant_nxt;
  logic              do_grant;
  logic [CNT_W-1:0]  beat_cnt;
  logic              lock;
  logic              sel_valid;
  logic              sel_last;
  logic [DATA_W-1:0] sel_data;
  logic              mul_hs;
  logic              frame_end;
  logic              fifo_head;
  logic              fifo_full;
  logic              fifo_empty;
  logic              fifo_pop;
  logic              route0;
  logic              route1;

  assign lock      = (state == LOCK);
  assign busy      = lock;
  assign sel_valid = grant_id ? s1_axis_tvalid : s0_axis_tvalid;
  assign sel_last  = grant_id ? s1_axis_tlast  : s0_axis_tlast;
  assign sel_data  = grant_id ? s1_axis_tdata  : s0_axis_tdata;

  // tlast is qualified by tvalid: the multiplier resets its position on tlast alone.
  assign mul_m_axis_tvalid = lock & sel_valid;
  assign mul_m_axis_tlast  = lock & sel_valid & sel_last;
  assign mul_m_axis_tdata  = lock ? sel_data : '0;
  assign s0_axis_tready    = lock & ~grant_id & mul_m_axis_tready;
  assign s1_axis_tready    = lock &  grant_id & mul_m_axis_tready;
  assign mul_hs            = mul_m_axis_tvalid & mul_m_axis_tready;
  assign frame_end         = mul_hs & mul_m_axis_tlast;

  // Next-state and grant selection; both valid alternates away from last winner.
  always_comb begin
    state_nxt = state;
    do_grant  = 1'b0;
    grant_nxt = grant_id;
    case (state)
      IDLE: begin
        if ((s0_axis_tvalid | s1_axis_tvalid) && !fifo_full) begin
          do_grant  = 1'b1;
          grant_nxt = (s0_axis_tvalid && s1_axis_tvalid) ? ~last_grant : s1_axis_tvalid;
          state_nxt = LOCK;
        end
      end
      LOCK: begin
        if (frame_end) state_nxt = IDLE;
      end
    endcase
  end

  // State register and grant bookkeeping; last_grant resets to 1 so ch0 wins first.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state      <= IDLE;
      grant_id   <= 1'b0;
      last_grant <= 1'b1;
    end else begin
      state <= state_nxt;
      if (do_grant) begin
        grant_id   <= grant_nxt;
        last_grant <= grant_nxt;
      end
    end
  end

  // Saturating beat counter and one-cycle length-error pulse after each tlast.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      beat_cnt  <= '0;
      frame_err <= 1'b0;
    end else begin
      frame_err <= frame_end && ((beat_cnt + CNT_W'(1)) != CNT_MAX);
      if (frame_end) begin
        beat_cnt <= '0;
      end else if (mul_hs && (beat_cnt != CNT_MAX)) begin
        beat_cnt <= beat_cnt + CNT_W'(1);
      end
    end
  end

  // Output routing follows the FIFO head with no added latency.
  assign route0            = ~fifo_empty & ~fifo_head;
  assign route1            = ~fifo_empty &  fifo_head;
  assign mul_s_axis_tready = (route0 & m0_axis_tready) | (route1 & m1_axis_tready);
  assign m0_axis_tvalid    = route0 & mul_s_axis_tvalid;
  assign m0_axis_tlast     = route0 & mul_s_axis_tlast;
  assign m0_axis_tdata     = route0 ? mul_s_axis_tdata : '0;
  assign m1_axis_tvalid    = route1 & mul_s_axis_tvalid;
  assign m1_axis_tlast     = route1 & mul_s_axis_tlast;
  assign m1_axis_tdata     = route1 ? mul_s_axis_tdata : '0;
  assign fifo_pop          = mul_s_axis_tvalid & mul_s_axis_tready & mul_s_axis_tlast;

  tag_fifo #(
    .DEPTH(TAG_DEPTH)
  ) u_tag_fifo (
    .aclk     (aclk),
    .aresetn  (aresetn),
    .push     (do_grant),
    .push_tag (grant_nxt),
    .pop      (fifo_pop),
    .head     (fifo_head),
    .full     (fifo_full),
    .empty    (fifo_empty)
  );

endmodule
